// File: rtl/riscv_mem_pipe.sv
// rtl/riscv_mem_pipe.sv - RISC-V MEM stage: EX intake, single-outstanding data bus, registered WB result
// Define RISCV_MEM_MISALIGN_TRAP_EN to trap misaligned H/W accesses instead of truncating them.
module riscv_mem_pipe #(
  parameter int XLEN = 32,
  parameter int REGW = 5
) (
  input  logic            clk,
  input  logic            rstn,
  input  logic            ex_mem_rdy,
  output logic            ex_mem_ack,
  input  logic [XLEN-1:0] ex_mem_result,
  input  logic [XLEN-1:0] ex_mem_wdata,
  input  logic            ex_mem_mem,
  input  logic            ex_mem_store,
  input  logic [2:0]      ex_mem_funct3,
  input  logic [REGW-1:0] ex_mem_rd,
  input  logic            ex_mem_we,
  output logic            dbus_req,
  input  logic            dbus_gnt,
  output logic            dbus_we,
  output logic [XLEN-1:0] dbus_addr,
  output logic [3:0]      dbus_be,
  output logic [XLEN-1:0] dbus_wdata,
  input  logic            dbus_rsp_vld,
  input  logic [XLEN-1:0] dbus_rdata,
  output logic            mem_wb_rdy,
  input  logic            mem_wb_ack,
  output logic [XLEN-1:0] mem_wb_data,
  output logic [REGW-1:0] mem_wb_rd,
  output logic            mem_wb_we,
  output logic            mem_wb_exc
);

  typedef enum logic [1:0] {IDLE = 2'd0, BUS_REQ = 2'd1, BUS_WAIT = 2'd2} state_t;
  localparam logic [1:0] SZ_B = 2'd0;
  localparam logic [1:0] SZ_H = 2'd1;
  localparam logic [1:0] SZ_W = 2'd2;

  state_t          r_state;
  state_t          w_state_nxt;
  logic [XLEN-1:0] r_addr;
  logic [XLEN-1:0] r_wdata;
  logic            r_store;
  logic            r_uns;
  logic            r_we;
  logic [1:0]      r_size;
  logic [REGW-1:0] r_rd;

  logic            r_out_vld;
  logic [XLEN-1:0] r_out_data;
  logic [REGW-1:0] r_out_rd;
  logic            r_out_we;

  logic            w_misalign;
  logic            w_load_out;
  logic            w_out_we;
  logic [1:0]      w_size;
  logic [XLEN-1:0] w_out_data;
  logic [XLEN-1:0] w_rd_data;
  logic [XLEN-1:0] w_wdata_rep;
  logic [REGW-1:0] w_out_rd;
  logic [3:0]      w_be;
  logic [7:0]      w_byte;
  logic [15:0]     w_half;

  // Reserved funct3 encodings fall through to word size.
  always_comb begin
    w_size = SZ_W;
    case (ex_mem_funct3)
      3'b000, 3'b100: w_size = SZ_B;
      3'b001, 3'b101: w_size = SZ_H;
      default:        w_size = SZ_W;
    endcase
  end

`ifdef RISCV_MEM_MISALIGN_TRAP_EN
  assign w_misalign = ex_mem_mem &&
                      (((w_size == SZ_H) && ex_mem_result[0]) ||
                       ((w_size == SZ_W) && (ex_mem_result[1:0] != 2'b00)));
`else
  assign w_misalign = 1'b0;
`endif

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) r_state <= IDLE;
    else       r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      IDLE:     if (ex_mem_rdy && ex_mem_ack && ex_mem_mem && !w_misalign) w_state_nxt = BUS_REQ;
      BUS_REQ:  if (dbus_gnt) w_state_nxt = r_store ? IDLE : BUS_WAIT;
      BUS_WAIT: if (dbus_rsp_vld) w_state_nxt = IDLE;
      default:  w_state_nxt = IDLE;
    endcase
  end

  always_comb begin
    ex_mem_ack = 1'b0;
    dbus_req   = 1'b0;
    w_load_out = 1'b0;
    w_out_data = '0;
    w_out_rd   = r_rd;
    w_out_we   = 1'b0;
    case (r_state)
      IDLE: begin
        ex_mem_ack = !r_out_vld || mem_wb_ack;
        if (ex_mem_rdy && ex_mem_ack && (!ex_mem_mem || w_misalign)) begin
          w_load_out = 1'b1;
          w_out_data = ex_mem_result;
          w_out_rd   = ex_mem_rd;
          w_out_we   = ex_mem_we && !w_misalign;
        end
      end
      BUS_REQ: begin
        dbus_req = 1'b1;
        if (dbus_gnt && r_store) w_load_out = 1'b1;
      end
      BUS_WAIT: begin
        if (dbus_rsp_vld) begin
          w_load_out = 1'b1;
          w_out_data = w_rd_data;
          w_out_we   = r_we;
        end
      end
      default: ;
    endcase
  end

  always_comb begin
    w_be        = 4'b1111;
    w_wdata_rep = r_wdata;
    case (r_size)
      SZ_B: begin
        w_be        = 4'b0001 << r_addr[1:0];
        w_wdata_rep = {4{r_wdata[7:0]}};
      end
      SZ_H: begin
        w_be        = r_addr[1] ? 4'b1100 : 4'b0011;
        w_wdata_rep = {2{r_wdata[15:0]}};
      end
      default: ;
    endcase
  end

  // Bus fields are only driven while requesting so the idle bus reads all-zero.
  always_comb begin
    dbus_we    = 1'b0;
    dbus_addr  = '0;
    dbus_be    = 4'b0000;
    dbus_wdata = '0;
    if (dbus_req) begin
      dbus_we    = r_store;
      dbus_addr  = {r_addr[XLEN-1:2], 2'b00};
      dbus_be    = w_be;
      dbus_wdata = w_wdata_rep;
    end
  end

  always_comb begin
    w_byte = dbus_rdata[7:0];
    case (r_addr[1:0])
      2'd0:    w_byte = dbus_rdata[7:0];
      2'd1:    w_byte = dbus_rdata[15:8];
      2'd2:    w_byte = dbus_rdata[23:16];
      default: w_byte = dbus_rdata[31:24];
    endcase
    w_half    = r_addr[1] ? dbus_rdata[31:16] : dbus_rdata[15:0];
    w_rd_data = dbus_rdata;
    case (r_size)
      SZ_B:    w_rd_data = r_uns ? {{(XLEN-8){1'b0}}, w_byte} : {{(XLEN-8){w_byte[7]}}, w_byte};
      SZ_H:    w_rd_data = r_uns ? {{(XLEN-16){1'b0}}, w_half} : {{(XLEN-16){w_half[15]}}, w_half};
      default: w_rd_data = dbus_rdata;
    endcase
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_addr  <= '0;
      r_wdata <= '0;
      r_store <= 1'b0;
      r_uns   <= 1'b0;
      r_we    <= 1'b0;
      r_size  <= SZ_B;
      r_rd    <= '0;
    end else if (ex_mem_rdy && ex_mem_ack && ex_mem_mem) begin
      r_addr  <= ex_mem_result;
      r_wdata <= ex_mem_wdata;
      r_store <= ex_mem_store;
      r_uns   <= ex_mem_funct3[2];
      r_we    <= ex_mem_we;
      r_size  <= w_size;
      r_rd    <= ex_mem_rd;
    end
  end

  // A new load wins over a drain on the same edge, giving 1/cycle throughput.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_out_vld  <= 1'b0;
      r_out_data <= '0;
      r_out_rd   <= '0;
      r_out_we   <= 1'b0;
    end else if (w_load_out) begin
      r_out_vld  <= 1'b1;
      r_out_data <= w_out_data;
      r_out_rd   <= w_out_rd;
      r_out_we   <= w_out_we;
    end else if (mem_wb_ack) begin
      r_out_vld  <= 1'b0;
    end
  end

`ifdef RISCV_MEM_MISALIGN_TRAP_EN
  logic r_out_exc;
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn)           r_out_exc <= 1'b0;
    else if (w_load_out) r_out_exc <= (r_state == IDLE) && w_misalign;
  end
  assign mem_wb_exc = r_out_exc;
`else
  assign mem_wb_exc = 1'b0;
`endif

  assign mem_wb_rdy  = r_out_vld;
  assign mem_wb_data = r_out_data;
  assign mem_wb_rd   = r_out_rd;
  assign mem_wb_we   = r_out_we;

endmodule

// File: tb/tb_riscv_mem_pipe.sv
// tb/tb_riscv_mem_pipe.sv - self-checking bench for riscv_mem_pipe
module tb_riscv_mem_pipe;

  logic        clk = 1'b0;
  logic        rstn = 1'b0;
  logic        ex_mem_rdy, ex_mem_ack, ex_mem_mem, ex_mem_store, ex_mem_we;
  logic [31:0] ex_mem_result, ex_mem_wdata;
  logic [2:0]  ex_mem_funct3;
  logic [4:0]  ex_mem_rd;
  logic        dbus_req, dbus_gnt, dbus_we, dbus_rsp_vld;
  logic [31:0] dbus_addr, dbus_wdata, dbus_rdata;
  logic [3:0]  dbus_be;
  logic        mem_wb_rdy, mem_wb_ack, mem_wb_we, mem_wb_exc;
  logic [31:0] mem_wb_data;
  logic [4:0]  mem_wb_rd;

  always #5 clk = ~clk;

  riscv_mem_pipe #(.XLEN(32), .REGW(5)) dut (
    .clk(clk), .rstn(rstn),
    .ex_mem_rdy(ex_mem_rdy), .ex_mem_ack(ex_mem_ack), .ex_mem_result(ex_mem_result),
    .ex_mem_wdata(ex_mem_wdata), .ex_mem_mem(ex_mem_mem), .ex_mem_store(ex_mem_store),
    .ex_mem_funct3(ex_mem_funct3), .ex_mem_rd(ex_mem_rd), .ex_mem_we(ex_mem_we),
    .dbus_req(dbus_req), .dbus_gnt(dbus_gnt), .dbus_we(dbus_we), .dbus_addr(dbus_addr),
    .dbus_be(dbus_be), .dbus_wdata(dbus_wdata), .dbus_rsp_vld(dbus_rsp_vld), .dbus_rdata(dbus_rdata),
    .mem_wb_rdy(mem_wb_rdy), .mem_wb_ack(mem_wb_ack), .mem_wb_data(mem_wb_data),
    .mem_wb_rd(mem_wb_rd), .mem_wb_we(mem_wb_we), .mem_wb_exc(mem_wb_exc)
  );

  typedef struct {
    logic [31:0] result, wdata;
    logic        mem, store;
    logic [2:0]  funct3;
    logic [4:0]  rd;
    logic        we;
    logic [31:0] rdata;
    int          gnt_dly, rsp_dly;
    logic        bus;
    logic [31:0] exp_addr;
    logic [3:0]  exp_be;
    logic [31:0] exp_bwdata, exp_data;
    logic        exp_we, exp_exc;
  } vec_t;

  typedef struct packed {logic [31:0] data; logic [4:0] rd; logic we; logic exc;} wb_t;
  typedef struct packed {logic [31:0] addr; logic [3:0] be; logic [31:0] wdata; logic we;} bus_t;

  wb_t  wb_q[$];
  bus_t bus_q[$];
  int   errors = 0;
  int   checks = 0;

  logic        cfg_auto = 1'b1;
  int          cfg_gnt_dly = 0, cfg_rsp_dly = 0;
  logic [31:0] cfg_rdata = '0;
  logic        r_gnt = 1'b0, r_rsp = 1'b0, m_gnt = 1'b0, m_rsp = 1'b0;
  logic [31:0] r_rdata = '0, m_rdata = '0;

  assign dbus_gnt     = cfg_auto ? r_gnt   : m_gnt;
  assign dbus_rsp_vld = cfg_auto ? r_rsp   : m_rsp;
  assign dbus_rdata   = cfg_auto ? r_rdata : m_rdata;

  task automatic chk(input string name, input logic [95:0] act, input logic [95:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic vec_t mk(input logic [31:0] res, wd, input logic mem, st, input logic [2:0] f3,
                              input logic [4:0] rd, input logic we, input logic [31:0] rdat,
                              input int gd, rsd, input logic bus, input logic [31:0] ea,
                              input logic [3:0] ebe, input logic [31:0] ebw, ed,
                              input logic ewe, eexc);
    vec_t v;
    v.result = res; v.wdata = wd; v.mem = mem; v.store = st; v.funct3 = f3; v.rd = rd; v.we = we;
    v.rdata = rdat; v.gnt_dly = gd; v.rsp_dly = rsd; v.bus = bus; v.exp_addr = ea; v.exp_be = ebe;
    v.exp_bwdata = ebw; v.exp_data = ed; v.exp_we = ewe; v.exp_exc = eexc;
    return v;
  endfunction

  task automatic set_op(input logic [31:0] res, wd, input logic mem, st,
                        input logic [2:0] f3, input logic [4:0] rd, input logic we);
    ex_mem_rdy = 1'b1; ex_mem_result = res; ex_mem_wdata = wd; ex_mem_mem = mem;
    ex_mem_store = st; ex_mem_funct3 = f3; ex_mem_rd = rd; ex_mem_we = we;
  endtask

  // Called just after a rising edge; returns just after the accepting edge.
  task automatic drive_op(input vec_t v);
    int t = 0;
    cfg_gnt_dly = v.gnt_dly; cfg_rsp_dly = v.rsp_dly; cfg_rdata = v.rdata;
    set_op(v.result, v.wdata, v.mem, v.store, v.funct3, v.rd, v.we);
    @(negedge clk);
    while (!ex_mem_ack && t < 100) begin @(negedge clk); t++; end
    chk("accept", ex_mem_ack, 1'b1);
    if (v.mem && v.bus) bus_q.push_back(bus_t'{v.exp_addr, v.exp_be, v.exp_bwdata, v.store});
    wb_q.push_back(wb_t'{v.exp_data, v.rd, v.exp_we, v.exp_exc});
    @(posedge clk); #1;
    ex_mem_rdy = 1'b0;
  endtask

  task automatic wait_idle();
    int t = 0;
    while (t < 100 && (wb_q.size() != 0 || bus_q.size() != 0 || !ex_mem_ack)) begin
      @(negedge clk); t++;
    end
    chk("drain", wb_q.size(), 0);
    @(posedge clk); #1;
  endtask

  // Writeback scoreboard: a transfer is due on the next rising edge.
  initial begin
    wb_t e;
    forever begin
      @(negedge clk);
      if (rstn && mem_wb_rdy && mem_wb_ack) begin
        if (wb_q.size() == 0) chk("wb_unexpected", wb_q.size(), 1);
        else begin
          e = wb_q.pop_front();
          chk("wb", {mem_wb_data, mem_wb_rd, mem_wb_we, mem_wb_exc}, e);
        end
      end
    end
  end

  // Data bus responder with configurable grant and response delays.
  initial begin
    bus_t e;
    forever begin
      @(negedge clk);
      r_gnt = 1'b0; r_rsp = 1'b0;
      if (cfg_auto && dbus_req) begin
        if (bus_q.size() == 0) begin
          chk("bus_unexpected", bus_q.size(), 1);
          e = bus_t'{dbus_addr, dbus_be, dbus_wdata, dbus_we};
        end else e = bus_q.pop_front();
        for (int k = 0; k <= cfg_gnt_dly; k++) begin
          if (k > 0) @(negedge clk);
          chk("bus_req_ack", {dbus_req, ex_mem_ack}, 2'b10);
          chk("bus_fields", {dbus_addr, dbus_be, dbus_wdata, dbus_we}, e);
        end
        r_gnt = 1'b1;
        @(negedge clk);
        r_gnt = 1'b0;
        chk("bus_req_drop", dbus_req, 1'b0);
        if (!e.we) begin
          for (int k = 0; k < cfg_rsp_dly; k++) @(negedge clk);
          r_rsp = 1'b1; r_rdata = cfg_rdata;
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1);
  end

  vec_t vecs[14];

  initial begin
    ex_mem_rdy = 0; ex_mem_result = 0; ex_mem_wdata = 0; ex_mem_mem = 0; ex_mem_store = 0;
    ex_mem_funct3 = 0; ex_mem_rd = 0; ex_mem_we = 0; mem_wb_ack = 1'b1;

    vecs[0]  = mk(32'h1234_5678, 0, 0, 0, 3'b010, 7, 1, 0, 0, 0, 0, 0, 4'h0, 0, 32'h1234_5678, 1, 0);
    vecs[1]  = mk(32'h0000_0103, 0, 1, 0, 3'b000, 3, 1, 32'h80FF_FFFF, 0, 0, 1, 32'h100, 4'b1000, 0, 32'hFFFF_FF80, 1, 0);
    vecs[2]  = mk(32'h0000_0103, 0, 1, 0, 3'b100, 4, 1, 32'h80FF_FFFF, 0, 0, 1, 32'h100, 4'b1000, 0, 32'h0000_0080, 1, 0);
    vecs[3]  = mk(32'h0000_0202, 32'h0000_ABCD, 1, 1, 3'b001, 5, 1, 0, 3, 0, 1, 32'h200, 4'b1100, 32'hABCD_ABCD, 0, 0, 0);
    vecs[4]  = mk(32'h0000_0102, 0, 1, 0, 3'b001, 6, 1, 32'h8001_7FFF, 1, 2, 1, 32'h100, 4'b1100, 0, 32'hFFFF_8001, 1, 0);
    vecs[5]  = mk(32'h0000_0100, 0, 1, 0, 3'b101, 8, 1, 32'h1234_F00D, 0, 0, 1, 32'h100, 4'b0011, 0, 32'h0000_F00D, 1, 0);
    vecs[6]  = mk(32'h0000_0400, 0, 1, 0, 3'b010, 9, 1, 32'hDEAD_BEEF, 2, 1, 1, 32'h400, 4'b1111, 0, 32'hDEAD_BEEF, 1, 0);
    vecs[7]  = mk(32'h0000_0501, 32'h1122_33A5, 1, 1, 3'b000, 10, 0, 0, 0, 0, 1, 32'h500, 4'b0010, 32'hA5A5_A5A5, 0, 0, 0);
    vecs[8]  = mk(32'h0000_0600, 32'hCAFE_F00D, 1, 1, 3'b010, 2, 0, 0, 1, 0, 1, 32'h600, 4'b1111, 32'hCAFE_F00D, 0, 0, 0);
    vecs[9]  = mk(32'h0000_0102, 0, 1, 0, 3'b000, 11, 1, 32'h0045_0000, 0, 3, 1, 32'h100, 4'b0100, 0, 32'h0000_0045, 1, 0);
    vecs[10] = mk(32'h0000_0704, 0, 1, 0, 3'b011, 12, 1, 32'h8765_4321, 0, 0, 1, 32'h704, 4'b1111, 0, 32'h8765_4321, 1, 0);
    vecs[11] = mk(32'hFFFF_FFFF, 0, 0, 0, 3'b000, 0, 1, 0, 0, 0, 0, 0, 4'h0, 0, 32'hFFFF_FFFF, 1, 0);
`ifdef RISCV_MEM_MISALIGN_TRAP_EN
    vecs[12] = mk(32'h0000_0301, 0, 1, 0, 3'b010, 13, 1, 32'h0A0B_0C0D, 0, 0, 0, 0, 4'h0, 0, 32'h0000_0301, 0, 1);
    vecs[13] = mk(32'h0000_0103, 0, 1, 0, 3'b001, 14, 1, 32'hBEEF_1234, 0, 0, 0, 0, 4'h0, 0, 32'h0000_0103, 0, 1);
`else
    vecs[12] = mk(32'h0000_0301, 0, 1, 0, 3'b010, 13, 1, 32'h0A0B_0C0D, 0, 0, 1, 32'h300, 4'b1111, 0, 32'h0A0B_0C0D, 1, 0);
    vecs[13] = mk(32'h0000_0103, 0, 1, 0, 3'b001, 14, 1, 32'hBEEF_1234, 0, 0, 1, 32'h100, 4'b1100, 0, 32'hFFFF_BEEF, 1, 0);
`endif

    repeat (3) @(negedge clk);
    chk("rst_rdy", mem_wb_rdy, 1'b0);
    chk("rst_wb", {mem_wb_data, mem_wb_rd, mem_wb_we, mem_wb_exc}, 0);
    chk("rst_bus", {dbus_req, dbus_we, dbus_addr, dbus_be, dbus_wdata}, 0);
    rstn = 1'b1;
    @(posedge clk); #1;
    chk("idle_ack", ex_mem_ack, 1'b1);

    for (int i = 0; i < 14; i++) begin
      drive_op(vecs[i]);
      wait_idle();
    end

    // Back-to-back non-memory ops with ex_mem_rdy held high.
    for (int i = 0; i < 4; i++) begin
      logic [31:0] d;
      logic [4:0]  r;
      d = 32'h100 + 32'(i);
      r = 5'(i + 1);
      set_op(d, 0, 0, 0, 3'b010, r, 1);
      @(negedge clk);
      chk("tput_ack", ex_mem_ack, 1'b1);
      if (i > 0) chk("tput_rdy", mem_wb_rdy, 1'b1);
      wb_q.push_back(wb_t'{d, r, 1'b1, 1'b0});
      @(posedge clk); #1;
    end
    ex_mem_rdy = 1'b0;
    wait_idle();

    // Backpressure: result held stable, upstream stalled, then same-edge refill.
    mem_wb_ack = 1'b0;
    drive_op(mk(32'hA5A5_0001, 0, 0, 0, 3'b010, 9, 1, 0, 0, 0, 0, 0, 4'h0, 0, 32'hA5A5_0001, 1, 0));
    set_op(32'h0B0B_0002, 0, 0, 0, 3'b010, 10, 0);
    repeat (5) begin
      @(negedge clk);
      chk("bp_rdy", mem_wb_rdy, 1'b1);
      chk("bp_hold", {mem_wb_data, mem_wb_rd, mem_wb_we}, {32'hA5A5_0001, 5'd9, 1'b1});
      chk("bp_ack", ex_mem_ack, 1'b0);
    end
    @(posedge clk); #1;
    mem_wb_ack = 1'b1;
    #1;
    chk("bp_ack_rise", ex_mem_ack, 1'b1);
    wb_q.push_back(wb_t'{32'h0B0B_0002, 5'd10, 1'b0, 1'b0});
    @(posedge clk); #1;
    ex_mem_rdy = 1'b0;
    @(negedge clk);
    chk("bp_next", {mem_wb_rdy, mem_wb_data}, {1'b1, 32'h0B0B_0002});
    wait_idle();

    // Reset during BUS_REQ drops dbus_req without a clock edge.
    cfg_auto = 1'b0;
    set_op(32'h800, 0, 1, 0, 3'b010, 15, 1);
    @(negedge clk);
    chk("rs1_ack", ex_mem_ack, 1'b1);
    @(posedge clk); #1;
    ex_mem_rdy = 1'b0;
    @(negedge clk);
    chk("rs1_req", dbus_req, 1'b1);
    #2 rstn = 1'b0;
    #1 chk("rs1_async", dbus_req, 1'b0);
    @(negedge clk);
    rstn = 1'b1;
    @(posedge clk); #1;

    // Reset during BUS_WAIT; the late response and a stray grant are ignored.
    set_op(32'h900, 0, 1, 0, 3'b010, 16, 1);
    @(negedge clk);
    chk("rs2_ack", ex_mem_ack, 1'b1);
    @(posedge clk); #1;
    ex_mem_rdy = 1'b0;
    m_gnt = 1'b1;
    @(posedge clk); #1;
    m_gnt = 1'b0;
    @(negedge clk);
    chk("rs2_wait_req", dbus_req, 1'b0);
    #1 rstn = 1'b0;
    @(negedge clk);
    rstn = 1'b1;
    @(posedge clk); #1;
    m_rsp = 1'b1; m_gnt = 1'b1; m_rdata = 32'h5555_AAAA;
    @(posedge clk); #1;
    m_rsp = 1'b0; m_gnt = 1'b0;
    repeat (3) begin
      @(negedge clk);
      chk("rs2_rdy", mem_wb_rdy, 1'b0);
      chk("rs2_req", dbus_req, 1'b0);
    end
    chk("rs2_wb", {mem_wb_data, mem_wb_rd, mem_wb_we, mem_wb_exc}, 0);
    chk("rs2_idle_ack", ex_mem_ack, 1'b1);
    @(posedge clk); #1;
    cfg_auto = 1'b1;

    // Machine still works after the aborted transaction.
    drive_op(vecs[6]);
    wait_idle();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/riscv_mem_pipe.md
Name: riscv_mem_pipe

Overview:
- MEM stage of the RISC-V pipeline, directly downstream of the EX stage.
- Consumes EX results over the ex_mem rdy/ack handshake and performs loads/stores on a single-outstanding data bus.
- Presents a single registered writeback result to the WB stage over the mem_wb rdy/ack handshake.
- Handshake rule on both sides: a transfer occurs on a rising clk edge where rdy && ack.

Parameters:
- XLEN, 32, data/address width; only 32 is supported.
- REGW, 5, destination register index width.

Ports:
- clk  in  1  clock
- rstn  in  1  reset, asynchronous, active-low
- ex_mem_rdy  in  1  EX result valid
- ex_mem_ack  out  1  stage accepts EX result
- ex_mem_result  in  XLEN  ALU result; memory address when ex_mem_mem=1
- ex_mem_wdata  in  XLEN  store data
- ex_mem_mem  in  1  memory access
- ex_mem_store  in  1  1=store, 0=load (valid when ex_mem_mem=1)
- ex_mem_funct3  in  3  RISC-V size: 000 B, 001 H, 010 W, 100 BU, 101 HU
- ex_mem_rd  in  REGW  destination register
- ex_mem_we  in  1  instruction writes rd
- dbus_req  out  1  bus request
- dbus_gnt  in  1  bus accepts request
- dbus_we  out  1  write
- dbus_addr  out  XLEN  word-aligned address, bits [1:0]=0
- dbus_be  out  4  byte enables
- dbus_wdata  out  XLEN  lane-replicated store data
- dbus_rsp_vld  in  1  read data valid
- dbus_rdata  in  XLEN  read data
- mem_wb_rdy  out  1  writeback valid
- mem_wb_ack  in  1  WB accepts
- mem_wb_data  out  XLEN  writeback value
- mem_wb_rd  out  REGW  destination register
- mem_wb_we  out  1  register write enable
- mem_wb_exc  out  1  misaligned-access exception

Behaviour:
- FSM states: IDLE, BUS_REQ, BUS_WAIT. Output register holds out_vld plus the mem_wb_* fields.
- Reset: state IDLE, out_vld=0, all outputs 0. Reset asserted mid-transaction aborts it; dbus_req falls asynchronously; no late result is produced.
- ex_mem_ack = (state==IDLE) && (!out_vld || mem_wb_ack). mem_wb_rdy = out_vld.
- Output fields stay stable while mem_wb_rdy=1 and mem_wb_ack=0.
- Non-memory op accepted: output register loads {ex_mem_result, rd, we} on the same edge. Latency 1.
- Memory op accepted: operands are latched, state goes to BUS_REQ, and out_vld clears if mem_wb_ack drained it.
- BUS_REQ: dbus_req=1 with stable addr/we/be/wdata until dbus_gnt.
  - Store + gnt: output loaded with we=0, data=0; state goes to IDLE. No response is expected.
  - Load + gnt: state goes to BUS_WAIT.
- BUS_WAIT: dbus_req=0. On dbus_rsp_vld, select the lane by addr[1:0], sign- or zero-extend per funct3, load the output register with we=ex_mem_we, and go to IDLE.
  - The output register is always empty at this point, because accept required it to be free.
- Load latency (accept to mem_wb_rdy) is 1 + gnt wait + rsp wait cycles. Minimum is 2, with gnt in the first BUS_REQ cycle and rsp in the cycle after.
- Byte enables:
  - B: 0001 shifted by addr[1:0].
  - H: 0011 shifted by {addr[1],0}.
  - W: 1111.
  - Store wdata is replicated: B ×4 byte, H ×2 halfword.
- dbus_rsp_vld outside BUS_WAIT is ignored.
- dbus_gnt is ignored while dbus_req=0.
- A request with rd=0 and we=1 is passed through as-is; the WB stage discards it.
- Invalid funct3 for a memory op (011, 110, 111) is treated as W.

Optional Feature:
- Macro: RISCV_MEM_MISALIGN_TRAP_EN.
- Defined:
  - A memory op is misaligned when it is H with addr[0]=1, or W with addr[1:0]≠0.
  - A misaligned op is accepted without any bus access and loads the output next cycle with mem_wb_exc=1, mem_wb_we=0, and mem_wb_data = faulting address.
- Undefined:
  - mem_wb_exc is tied 0.
  - Misaligned offsets are truncated to natural alignment (H uses addr[1], W uses the word), and the access proceeds.

Test Plan:
- Non-memory passthrough: result=0x1234_5678, rd=7, we=1, mem_wb_ack=1 → mem_wb_rdy one cycle later; data 0x12345678, rd 7, we 1. With ex_mem_rdy held high, back-to-back throughput is 1 per cycle.
- LB sign-extension: addr=0x103, rdata=0x80FF_FFFF, gnt immediate, rsp next cycle → dbus_addr 0x100, be 1000; mem_wb_data 0xFFFF_FF80. LBU with the same inputs → 0x0000_0080.
- SH: addr=0x202, wdata=0x0000_ABCD, gnt delayed 3 cycles → dbus_req held 4 cycles with stable fields; be 1100, wdata 0xABCD_ABCD; mem_wb_we=0; ex_mem_ack=0 throughout.
- Backpressure: mem_wb_ack=0 for 5 cycles with a result pending → mem_wb fields stable and ex_mem_ack=0. When ack rises, the next op is accepted on the same edge.
- Reset mid-load: rstn low in BUS_WAIT, then rsp arrives after release → dbus_req=0 immediately; mem_wb_rdy stays 0; the stale rsp is ignored.
- Misaligned trap (macro defined): LW addr=0x301 → no dbus_req; next cycle mem_wb_exc=1, data 0x301. With the macro undefined: dbus_addr 0x300, be 1111, exc 0.
